// File: rtl/wb_regfile_if.sv
// EX <-> writeback handshake and forwarding read-port bundle.
// The EX stage drives the master side; the writeback/register file drives the slave side.
interface wb_regfile_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_result;
  logic [SEL_W-1:0]  ex_dest;
  logic              ex_reg_we;
  logic [3:0]        ex_flags;
  logic              ex_flags_we;
  logic [SEL_W-1:0]  rd1_sel;
  logic [SEL_W-1:0]  rd2_sel;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic [3:0]        flags;

  modport master (
    output ex_valid, ex_result, ex_dest, ex_reg_we, ex_flags, ex_flags_we,
    output rd1_sel, rd2_sel,
    input  ex_ready, rd1_data, rd2_data, flags
  );

  modport slave (
    input  ex_valid, ex_result, ex_dest, ex_reg_we, ex_flags, ex_flags_we,
    input  rd1_sel, rd2_sel,
    output ex_ready, rd1_data, rd2_data, flags
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: one-entry pending slot in front of the 8x16 register file and NZCV flags,
// with combinational forwarding of the pending result/flags back to EX.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_regfile_if.slave ex,
  input  logic        wb_hold,
  output logic        wb_valid,
  output logic [15:0] commit_count
);
  localparam int SEL_W = $clog2(NREG);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [3:0]        flags_r;
  logic              p_v_r;
  logic [DATA_W-1:0] p_result_r;
  logic [SEL_W-1:0]  p_dest_r;
  logic              p_reg_we_r;
  logic [3:0]        p_flags_r;
  logic              p_flags_we_r;
  logic [15:0]       count_r;

  logic ready_s;
  logic accept_s;
  logic commit_s;

  // Handshake: a held slot blocks EX, otherwise commit and accept overlap with no bubble
  always_comb begin
    ready_s  = ~p_v_r | ~wb_hold;
    accept_s = ex.ex_valid & ready_s;
    commit_s = p_v_r & ~wb_hold;
  end

  // Pending slot, architectural registers, flags and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      flags_r      <= 4'b0000;
      p_v_r        <= 1'b0;
      p_result_r   <= {DATA_W{1'b0}};
      p_dest_r     <= {SEL_W{1'b0}};
      p_reg_we_r   <= 1'b0;
      p_flags_r    <= 4'b0000;
      p_flags_we_r <= 1'b0;
      count_r      <= 16'h0000;
    end else begin
      if (commit_s) begin
        if (p_reg_we_r) begin
          regs_r[p_dest_r] <= p_result_r;
        end
        if (p_flags_we_r) begin
          flags_r <= p_flags_r;
        end
        count_r <= count_r + 16'd1;
      end
      // A new entry overwrites the slot on the same edge the old one retires
      if (accept_s) begin
        p_v_r        <= 1'b1;
        p_result_r   <= ex.ex_result;
        p_dest_r     <= ex.ex_dest;
        p_reg_we_r   <= ex.ex_reg_we;
        p_flags_r    <= ex.ex_flags;
        p_flags_we_r <= ex.ex_flags_we;
      end else if (commit_s) begin
        p_v_r <= 1'b0;
      end
    end
  end

  // Forwarding: the slot shadows the register file until the edge that writes it back
  always_comb begin
    if (p_v_r && p_reg_we_r && (p_dest_r == ex.rd1_sel)) begin
      ex.rd1_data = p_result_r;
    end else begin
      ex.rd1_data = regs_r[ex.rd1_sel];
    end
    if (p_v_r && p_reg_we_r && (p_dest_r == ex.rd2_sel)) begin
      ex.rd2_data = p_result_r;
    end else begin
      ex.rd2_data = regs_r[ex.rd2_sel];
    end
    if (p_v_r && p_flags_we_r) begin
      ex.flags = p_flags_r;
    end else begin
      ex.flags = flags_r;
    end
  end

  assign ex.ex_ready    = ready_s;
  assign wb_valid       = p_v_r;
  assign commit_count   = count_r;
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 16-bit core. It sits directly downstream of the EX stage. It captures each EX result (ALU_results, destination register, flag update) in a one-entry pending slot and commits it to the 8 x 16-bit register file and the NZCV flag register one cycle later. It also supplies the forwarded op_1/op_2 register values and flags back to EX.

## Interface
Parameters:
- DATA_W, 16, register and result width
- NREG, 8, number of general registers (3-bit select)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX presents a completed instruction this cycle
- ex_ready  out  1  slot can accept this cycle
- ex_result  in  16  ALU_results from EX
- ex_dest  in  3  destination register index
- ex_reg_we  in  1  result is to be written to ex_dest
- ex_flags  in  4  {N,Z,C,V} produced by EX
- ex_flags_we  in  1  flags are to be updated
- wb_hold  in  1  freezes commit (the slot retains its contents)
- rd1_sel  in  3  op_1 register select
- rd2_sel  in  3  op_2 register select
- rd1_data  out  16  forwarded op_1_reg_value
- rd2_data  out  16  forwarded op_2_reg_value
- flags  out  4  forwarded flags to EX
- wb_valid  out  1  pending slot occupied
- commit_count  out  16  retired-instruction counter

## Operation
- State: regfile R[0..7]; flag register F[3:0]; pending slot P = {v, result, dest, reg_we, flags, flags_we}; 16-bit counter C.
- Accept = ex_valid & ex_ready. On accept, all ex_* fields load into P and P.v is set to 1.
- Commit = P.v & ~wb_hold. On commit:
  - if P.reg_we, R[P.dest] <= P.result;
  - if P.flags_we, F <= P.flags;
  - C <= C+1, wrapping 0xFFFF->0x0000.
- ex_ready = ~P.v | ~wb_hold.
  - Accept and commit in the same cycle are legal. The old P commits and the new entry replaces it. There is no bubble.
- P.v next-state:
  - accept -> 1;
  - else commit -> 0;
  - else unchanged.
- An entry with reg_we = 0 and flags_we = 0 (a NOP) still occupies the slot, commits, and increments C.
- All 8 registers are writable. R0 is not hardwired.
- Read forwarding (combinational, for each port):
  - rdN_data = P.result when P.v & P.reg_we & (P.dest == rdN_sel);
  - otherwise rdN_data = R[rdN_sel].
  - Forwarding applies regardless of wb_hold.
- Flags forwarding: flags = P.flags when P.v & P.flags_we; otherwise flags = F.
- ex_* inputs are don't-care while ex_valid = 0 or ex_ready = 0. When ex_valid & ~ex_ready, EX must hold the same values until acceptance.
- wb_valid = P.v.

## Timing
- Reset (rst_n low, asynchronous): R[all] = 0, F = 0, P.v = 0, C = 0. Outputs during reset: ex_ready = 1, wb_valid = 0, rd1_data = rd2_data = 0, flags = 0, commit_count = 0.
- Reset mid-operation: the pending entry is discarded and is never committed. Release of rst_n is synchronous to clk externally.
- Latency: accepted at edge N.
  - Visible through forwarding immediately after edge N.
  - Architectural (R/F updated) at edge N+1 if wb_hold = 0 in cycle N+1.
  - Each held cycle adds one cycle.
- Throughput: one instruction per cycle while wb_hold = 0.
- Back-to-back writes to the same dest:
  - the younger entry forwards;
  - the older entry commits to R on the same edge the younger is accepted;
  - final R value is the younger entry's result.
- Reads are combinational from registered state. There is no read-during-commit race, because the slot forwards until the edge that writes R.
- C counts commits only. Held cycles and reset do not count.

## Test plan
- Reset: assert rst_n = 0 mid-stream with P.v = 1 -> immediately wb_valid = 0, flags = 0, rd1_data = 0 for every sel, commit_count = 0. After release, R3 reads 0.
- Single write: accept {result = 0x1234, dest = 3, reg_we = 1, flags = 4'b0000, flags_we = 1}, rd1_sel = 3.
  - Cycle N+1: rd1_data = 0x1234 via forwarding.
  - After edge N+1: R3 = 0x1234, F = 0, commit_count = 1.
- Back-to-back: accept dest = 2 with 0x0005, then dest = 2 with 0xFFFF on consecutive cycles -> rd2_data (sel = 2) shows 0x0005 then 0xFFFF. Final R2 = 0xFFFF, commit_count = 2, no stall.
- Hold: with P.v = 1 (dest = 1, 0x00AA), assert wb_hold for 3 cycles with ex_valid = 1 -> ex_ready = 0 for 3 cycles, R1 unchanged, rd1_data (sel = 1) = 0x00AA throughout. The held EX entry is accepted on the cycle wb_hold drops.
- Flags-only: accept {reg_we = 0, flags = 4'b0100, flags_we = 1} -> flags = 4'b0100 one cycle before F updates; no register changes; commit_count increments.
- Counter wrap: preload via 65535 NOP commits, then one more -> commit_count = 0x0000.
